// File: rtl/fifo_flush_seq.sv
// FIFO flush sequencer: zero-pads the partial longword, drains the FIFO by DMA, then raises STOPFLUSH.
// Optional bus-grant watchdog enabled by defining FLUSH_TIMEOUT_EN.
module fifo_flush_seq #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int TMO_W       = 8
) (
   input  logic             CLK,
   input  logic             CLR_FLUSHFIFO,
   input  logic             FLUSHFIFO,
   input  logic             DMADIR,
   input  logic             DMAENA,
   input  logic [1:0]       BYTE_PTR,
   input  logic             FIFOEMPTY,
   input  logic             BGRANT,
   input  logic             CYCDONE,
   output logic             PAD_WR,
   output logic             DMA_REQ,
   output logic             FLUSH_BUSY,
   output logic             STOPFLUSH,
   output logic [CNT_W-1:0] FLUSH_CNT,
   output logic             FLUSH_ERR
);
   localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   typedef enum logic [2:0] {
      S_IDLE, S_PAD, S_GAP, S_DRAIN, S_XFER, S_DONE
   } state_t;

   logic [SYNC_N-1:0] r_sync;
   state_t            r_state;
   logic [1:0]        r_pad_cnt;
   logic              r_pad_wr;
   logic              r_dma_req;
   logic              r_stop;
   logic [CNT_W-1:0]  r_cnt;
   logic              w_flush_s;
   logic              w_cyc_ok;
   logic              w_tmo_hit;

   always_ff @(posedge CLK or negedge CLR_FLUSHFIFO) begin
      if (!CLR_FLUSHFIFO) r_sync <= '0;
      else                r_sync <= {r_sync[SYNC_N-2:0], FLUSHFIFO};
   end

   assign w_flush_s = r_sync[SYNC_N-1];
   // A completion strobe only counts while the bus is actually ours.
   assign w_cyc_ok  = CYCDONE & BGRANT;

`ifdef FLUSH_TIMEOUT_EN
   logic [TMO_W-1:0] r_tmo;
   logic             r_err;

   always_ff @(posedge CLK or negedge CLR_FLUSHFIFO) begin
      if (!CLR_FLUSHFIFO)            r_tmo <= '0;
      else if (!r_dma_req || BGRANT) r_tmo <= '0;
      else                           r_tmo <= r_tmo + 1'b1;
   end

   assign w_tmo_hit = r_dma_req & ~BGRANT & (r_tmo == {{(TMO_W-1){1'b1}}, 1'b0});

   always_ff @(posedge CLK or negedge CLR_FLUSHFIFO) begin
      if (!CLR_FLUSHFIFO) r_err <= 1'b0;
      else if (w_tmo_hit) r_err <= 1'b1;
   end

   assign FLUSH_ERR = r_err;
`else
   assign w_tmo_hit = 1'b0;
   // Constant 0 for any legal TMO_W; the watchdog is not built.
   assign FLUSH_ERR = (TMO_W < 1);
`endif

   always_ff @(posedge CLK or negedge CLR_FLUSHFIFO) begin
      if (!CLR_FLUSHFIFO) begin
         r_state   <= S_IDLE;
         r_pad_cnt <= '0;
         r_pad_wr  <= 1'b0;
         r_dma_req <= 1'b0;
         r_stop    <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_pad_wr <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_flush_s) begin
                  r_cnt     <= '0;
                  r_pad_cnt <= '0;
                  if (DMADIR || !DMAENA) begin
                     r_state <= S_DONE;
                     r_stop  <= 1'b1;
                  end else if (BYTE_PTR != 2'd0) begin
                     r_state   <= S_PAD;
                     r_pad_wr  <= 1'b1;
                     r_pad_cnt <= 2'd1;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end
            end
            S_PAD: r_state <= S_GAP;
            S_GAP: begin
               // BYTE_PTR has absorbed the previous pad byte by now.
               if (!w_flush_s) begin
                  r_state <= S_IDLE;
               end else if (BYTE_PTR != 2'd0 && r_pad_cnt != 2'd3) begin
                  r_state   <= S_PAD;
                  r_pad_wr  <= 1'b1;
                  r_pad_cnt <= r_pad_cnt + 1'b1;
               end else begin
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (!w_flush_s) begin
                  r_state <= S_IDLE;
               end else if (FIFOEMPTY) begin
                  r_state <= S_DONE;
                  r_stop  <= 1'b1;
               end else begin
                  r_state   <= S_XFER;
                  r_dma_req <= 1'b1;
               end
            end
            S_XFER: begin
               if (w_cyc_ok) begin
                  r_dma_req <= 1'b0;
                  if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + 1'b1;
                  r_state <= w_flush_s ? S_DRAIN : S_IDLE;
               end else if (w_tmo_hit) begin
                  r_dma_req <= 1'b0;
                  r_state   <= S_DONE;
                  r_stop    <= 1'b1;
               end
            end
            S_DONE: begin
               if (!w_flush_s) begin
                  r_state <= S_IDLE;
                  r_stop  <= 1'b0;
               end
            end
            default: begin
               r_state   <= S_IDLE;
               r_dma_req <= 1'b0;
               r_stop    <= 1'b0;
            end
         endcase
      end
   end

   assign PAD_WR     = r_pad_wr;
   assign DMA_REQ    = r_dma_req;
   assign STOPFLUSH  = r_stop;
   assign FLUSH_CNT  = r_cnt;
   assign FLUSH_BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_fifo_flush_seq.sv
// Bench for fifo_flush_seq: directed flush scenarios plus randomized flushes checked
// against a transaction-level model of pads, DMA cycles and drained longwords.
module tb_fifo_flush_seq;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_W       = 4;
   localparam int TMO_W       = 8;
   localparam int CNT_MAX     = (1 << CNT_W) - 1;

   logic             CLK = 1'b0;
   logic             rst_n;
   logic             loop_en;
   logic             w_loop_clr;
   logic             clr_n;
   logic             FLUSHFIFO, DMADIR, DMAENA, FIFOEMPTY, BGRANT, CYCDONE;
   logic [1:0]       BYTE_PTR;
   logic             PAD_WR, DMA_REQ, FLUSH_BUSY, STOPFLUSH, FLUSH_ERR;
   logic [CNT_W-1:0] FLUSH_CNT;

   int  n_chk = 0, n_pass = 0, n_fail = 0;
   int  pads, reqs, fifo_lw;
   int  stop_pulses = 0;
   logic req_prev = 1'b0;
   bit  auto_bus;

   always #5 CLK = ~CLK;

   // Register-block loop: STOPFLUSH clears the flag, which resets the sequencer.
   assign #2 w_loop_clr = ~STOPFLUSH;
   assign clr_n = rst_n & (~loop_en | w_loop_clr);

   always @(posedge STOPFLUSH) stop_pulses++;

   fifo_flush_seq #(.SYNC_STAGES(SYNC_STAGES), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
      .CLK(CLK), .CLR_FLUSHFIFO(clr_n), .FLUSHFIFO(FLUSHFIFO), .DMADIR(DMADIR),
      .DMAENA(DMAENA), .BYTE_PTR(BYTE_PTR), .FIFOEMPTY(FIFOEMPTY), .BGRANT(BGRANT),
      .CYCDONE(CYCDONE), .PAD_WR(PAD_WR), .DMA_REQ(DMA_REQ), .FLUSH_BUSY(FLUSH_BUSY),
      .STOPFLUSH(STOPFLUSH), .FLUSH_CNT(FLUSH_CNT), .FLUSH_ERR(FLUSH_ERR)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   // One clock; then play byte-pointer logic, FIFO and bus slave against the outputs.
   task automatic step();
      @(posedge CLK);
      #1;
      if (auto_bus) begin
         if (CYCDONE) begin
            CYCDONE = 1'b0;
            if (fifo_lw > 0) fifo_lw--;
         end else if (DMA_REQ) begin
            if (!BGRANT) BGRANT = ($urandom_range(0, 2) != 0);
            else if ($urandom_range(0, 1) == 1) CYCDONE = 1'b1;
         end else begin
            BGRANT = ($urandom_range(0, 1) == 1);
         end
      end
      FIFOEMPTY = (fifo_lw == 0);
      if (PAD_WR) begin
         pads++;
         BYTE_PTR = BYTE_PTR + 2'd1;
      end
      if (DMA_REQ && !req_prev) reqs++;
      req_prev = DMA_REQ;
   endtask

   task automatic run_flush(input string tag, input bit dir, input bit ena,
                            input logic [1:0] bp, input int lw, output int cyc);
      bit drains;
      int exp_pads, exp_reqs, exp_cnt;
      drains   = !dir && ena;
      exp_pads = drains ? (4 - int'(bp)) % 4 : 0;
      exp_reqs = drains ? lw : 0;
      exp_cnt  = (exp_reqs > CNT_MAX) ? CNT_MAX : exp_reqs;
      DMADIR = dir; DMAENA = ena; BYTE_PTR = bp; fifo_lw = lw; FIFOEMPTY = (lw == 0);
      CYCDONE = 1'b0; pads = 0; reqs = 0; auto_bus = 1'b1;
      FLUSHFIFO = 1'b1;
      cyc = 0;
      while (!STOPFLUSH && cyc < 2000) begin
         step();
         cyc++;
      end
      chk({tag, ".stop"}, int'(STOPFLUSH), 1);
      chk({tag, ".busy"}, int'(FLUSH_BUSY), 1);
      chk({tag, ".pads"}, pads, exp_pads);
      chk({tag, ".reqs"}, reqs, exp_reqs);
      chk({tag, ".cnt"}, int'(FLUSH_CNT), exp_cnt);
      chk({tag, ".left"}, fifo_lw, drains ? 0 : lw);
      chk({tag, ".err"}, int'(FLUSH_ERR), 0);
      FLUSHFIFO = 1'b0;
      repeat (SYNC_STAGES + 2) step();
      chk({tag, ".release"}, int'({STOPFLUSH, FLUSH_BUSY}), 0);
   endtask

   initial begin
      int cyc, base;
      rst_n = 1'b1; loop_en = 1'b0; auto_bus = 1'b0;
      FLUSHFIFO = 1'b0; DMADIR = 1'b0; DMAENA = 1'b0; BYTE_PTR = 2'd0;
      FIFOEMPTY = 1'b1; BGRANT = 1'b0; CYCDONE = 1'b0; fifo_lw = 0;
      #1 rst_n = 1'b0;
      #1;
      chk("rst.pad", int'(PAD_WR), 0);
      chk("rst.req", int'(DMA_REQ), 0);
      chk("rst.busy", int'(FLUSH_BUSY), 0);
      chk("rst.stop", int'(STOPFLUSH), 0);
      chk("rst.cnt", int'(FLUSH_CNT), 0);
      chk("rst.err", int'(FLUSH_ERR), 0);
      repeat (3) @(posedge CLK);
      #1 rst_n = 1'b1;
      step();

      run_flush("pad3", 1'b0, 1'b1, 2'd1, 2, cyc);
      run_flush("dir1", 1'b1, 1'b1, 2'd2, 3, cyc);
      chk("dir1.lat", int'(cyc <= SYNC_STAGES + 2), 1);
      run_flush("empty", 1'b0, 1'b1, 2'd0, 0, cyc);
      run_flush("ena0", 1'b0, 1'b0, 2'd1, 2, cyc);
      run_flush("sat", 1'b0, 1'b1, 2'd3, 17, cyc);
      for (int i = 0; i < 12; i++) begin
         run_flush($sformatf("rnd%0d", i), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 4) != 0), 2'($urandom_range(0, 3)),
                   int'($urandom_range(0, 5)), cyc);
      end

      // Stray CYCDONE, then flush withdrawn while a cycle is outstanding.
      auto_bus = 1'b0; BGRANT = 1'b0; CYCDONE = 1'b0;
      DMADIR = 1'b0; DMAENA = 1'b1; BYTE_PTR = 2'd0; fifo_lw = 2; FIFOEMPTY = 1'b0;
      FLUSHFIFO = 1'b1;
      cyc = 0;
      while (!DMA_REQ && cyc < 20) begin step(); cyc++; end
      chk("wd.req_up", int'(DMA_REQ), 1);
      CYCDONE = 1'b1;
      step();
      CYCDONE = 1'b0;
      step();
      chk("nogrant.req", int'(DMA_REQ), 1);
      chk("nogrant.cnt", int'(FLUSH_CNT), 0);
      FLUSHFIFO = 1'b0;
      fifo_lw = 0;
      repeat (SYNC_STAGES + 3) step();
      chk("wd.req_held", int'(DMA_REQ), 1);
      chk("wd.busy_held", int'(FLUSH_BUSY), 1);
      BGRANT = 1'b1; CYCDONE = 1'b1;
      step();
      CYCDONE = 1'b0; BGRANT = 1'b0;
      chk("wd.req_drop", int'(DMA_REQ), 0);
      chk("wd.cnt", int'(FLUSH_CNT), 1);
      chk("wd.idle", int'({STOPFLUSH, FLUSH_BUSY}), 0);

      // Asynchronous reset while a DMA request is pending.
      fifo_lw = 3; FIFOEMPTY = 1'b0; BGRANT = 1'b0;
      step();
      FLUSHFIFO = 1'b1;
      cyc = 0;
      while (!DMA_REQ && cyc < 20) begin step(); cyc++; end
      chk("ar.req_up", int'(DMA_REQ), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar.req", int'(DMA_REQ), 0);
      chk("ar.busy", int'(FLUSH_BUSY), 0);
      FLUSHFIFO = 1'b0;
      @(posedge CLK);
      #1 rst_n = 1'b1;
      reqs = 0; pads = 0;
      repeat (5) step();
      chk("ar.quiet", pads + reqs + int'(FLUSH_BUSY), 0);
      run_flush("restart", 1'b0, 1'b1, 2'd2, 1, cyc);

      // Closed loop: STOPFLUSH resets the block and clears the flag.
      auto_bus = 1'b0; BGRANT = 1'b0;
      loop_en = 1'b1;
      base = stop_pulses;
      DMADIR = 1'b1;
      FLUSHFIFO = 1'b1;
      cyc = 0;
      while (stop_pulses == base && cyc < 20) begin step(); cyc++; end
      FLUSHFIFO = 1'b0;
      repeat (8) step();
      chk("loop.pulses", stop_pulses - base, 1);
      chk("loop.idle", int'({STOPFLUSH, FLUSH_BUSY, DMA_REQ}), 0);
      chk("loop.clr", int'(clr_n), 1);
      loop_en = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
